// File: rtl/encoder32_5_serial_if.sv
// Handshake bundle for encoder32_5_serial: vector input side plus indexed output side.
// The slave modport is the encoder's view; the master modport is the producer/consumer view.
interface encoder32_5_serial_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_vec;
  logic        out_valid;
  logic        out_ready;
  logic [4:0]  out_idx;
  logic        out_last;
  logic [5:0]  pending;
  logic        empty_err;

  modport slave (
    input  in_valid, in_vec, out_ready,
    output in_ready, out_valid, out_idx, out_last, pending, empty_err
  );

  modport master (
    output in_valid, in_vec, out_ready,
    input  in_ready, out_valid, out_idx, out_last, pending, empty_err
  );
endinterface

// File: rtl/encoder32_5_serial.sv
// Serialising 32-to-5 encoder: latches a multi-hot vector and emits the index of each set bit,
// one per accepted beat, in LSB-first or MSB-first priority order.
module encoder32_5_serial #(
  parameter bit LSB_FIRST = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  encoder32_5_serial_if.slave   bus
);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    SCAN = 1'b1
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] pend_q, pend_d;
  logic [5:0]  pending_q, pending_d;
  logic        empty_err_q, empty_err_d;
  logic [4:0]  pri_idx;
  logic        out_valid;
  logic        out_last;

  // Highest-priority set bit; the later match in the loop wins, so scan order selects priority.
  function automatic logic [4:0] pri_enc(input logic [31:0] v);
    logic [4:0] idx;
    idx = '0;
    if (LSB_FIRST) begin
      for (int i = 31; i >= 0; i--) begin
        if (v[i]) idx = 5'(i);
      end
    end else begin
      for (int i = 0; i < 32; i++) begin
        if (v[i]) idx = 5'(i);
      end
    end
    return idx;
  endfunction

  function automatic logic [5:0] popcount(input logic [31:0] v);
    logic [5:0] cnt;
    cnt = '0;
    for (int i = 0; i < 32; i++) begin
      cnt = cnt + {5'd0, v[i]};
    end
    return cnt;
  endfunction

  assign pri_idx   = pri_enc(pend_q);
  assign out_valid = (state_q == SCAN);
  assign out_last  = out_valid && (pending_q == 6'd1);

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = out_valid;
  assign bus.out_idx   = out_valid ? pri_idx : 5'd0;
  assign bus.out_last  = out_last;
  assign bus.pending   = pending_q;
  assign bus.empty_err = empty_err_q;

  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latch).
    state_d     = state_q;
    pend_d      = pend_q;
    pending_d   = pending_q;
    empty_err_d = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          if (bus.in_vec != 32'd0) begin
            pend_d    = bus.in_vec;
            pending_d = popcount(bus.in_vec);
            state_d   = SCAN;
          end else begin
            empty_err_d = 1'b1;
          end
        end
      end
      SCAN: begin
        // Without out_ready everything holds, so the presented beat stays stable.
        if (bus.out_ready) begin
          pend_d    = pend_q & ~(32'd1 << pri_idx);
          pending_d = pending_q - 6'd1;
          if (out_last) state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every register samples the pre-edge value of the others.
    if (rst) begin
      // NOTE: pend_q is cleared too, so a reset mid-SCAN discards the remaining indices.
      state_q     <= IDLE;
      pend_q      <= '0;
      pending_q   <= '0;
      empty_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      pend_q      <= pend_d;
      pending_q   <= pending_d;
      empty_err_q <= empty_err_d;
    end
  end

endmodule

// File: tb/tb_encoder32_5_serial.sv
// Directed self-checking bench for encoder32_5_serial; a second instance with LSB_FIRST=0
// covers the MSB-first ordering.
module tb_encoder32_5_serial;

  logic clk;
  logic rst;
  int   tests_run;
  int   tests_failed;

  encoder32_5_serial_if bus_a ();
  encoder32_5_serial_if bus_b ();

  encoder32_5_serial #(.LSB_FIRST(1'b1)) dut_a (.clk(clk), .rst(rst), .bus(bus_a));
  encoder32_5_serial #(.LSB_FIRST(1'b0)) dut_b (.clk(clk), .rst(rst), .bus(bus_b));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Outputs are sampled 1 time unit after the rising edge; inputs change at the same point.
  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [4:0] exp_a [3];
    logic [4:0] exp_b [3];
    tests_run    = 0;
    tests_failed = 0;

    rst             = 1'b1;
    bus_a.in_valid  = 1'b0;
    bus_a.in_vec    = 32'd0;
    bus_a.out_ready = 1'b0;
    bus_b.in_valid  = 1'b0;
    bus_b.in_vec    = 32'd0;
    bus_b.out_ready = 1'b0;
    tick();
    tick();
    rst = 1'b0;

    // Reset state
    check("rst_in_ready",  bus_a.in_ready,  1);
    check("rst_out_valid", bus_a.out_valid, 0);
    check("rst_out_idx",   bus_a.out_idx,   0);
    check("rst_out_last",  bus_a.out_last,  0);
    check("rst_pending",   bus_a.pending,   0);
    check("rst_empty_err", bus_a.empty_err, 0);

    // Test 1: single bit 0
    bus_a.in_vec    = 32'h0000_0001;
    bus_a.in_valid  = 1'b1;
    bus_a.out_ready = 1'b1;
    tick();
    bus_a.in_valid = 1'b0;
    check("t1_valid",    bus_a.out_valid, 1);
    check("t1_idx",      bus_a.out_idx,   0);
    check("t1_last",     bus_a.out_last,  1);
    check("t1_pending",  bus_a.pending,   1);
    check("t1_in_ready", bus_a.in_ready,  0);
    tick();
    check("t1_idle_ready", bus_a.in_ready,  1);
    check("t1_idle_valid", bus_a.out_valid, 0);

    // Test 2: 8000_0011 in both priority orders
    exp_a = '{5'd0, 5'd4, 5'd31};
    exp_b = '{5'd31, 5'd4, 5'd0};
    bus_a.in_vec    = 32'h8000_0011;
    bus_b.in_vec    = 32'h8000_0011;
    bus_a.in_valid  = 1'b1;
    bus_b.in_valid  = 1'b1;
    bus_b.out_ready = 1'b1;
    tick();
    bus_a.in_valid = 1'b0;
    bus_b.in_valid = 1'b0;
    for (int b = 0; b < 3; b++) begin
      check($sformatf("t2_valid_a%0d", b),   bus_a.out_valid, 1);
      check($sformatf("t2_idx_a%0d", b),     bus_a.out_idx,   exp_a[b]);
      check($sformatf("t2_idx_b%0d", b),     bus_b.out_idx,   exp_b[b]);
      check($sformatf("t2_pending_a%0d", b), bus_a.pending,   3 - b);
      check($sformatf("t2_pending_b%0d", b), bus_b.pending,   3 - b);
      check($sformatf("t2_last_a%0d", b),    bus_a.out_last,  (b == 2) ? 1 : 0);
      check($sformatf("t2_last_b%0d", b),    bus_b.out_last,  (b == 2) ? 1 : 0);
      tick();
    end
    check("t2_done_ready_a", bus_a.in_ready,  1);
    check("t2_done_ready_b", bus_b.in_ready,  1);
    check("t2_done_valid_b", bus_b.out_valid, 0);
    bus_b.out_ready = 1'b0;

    // Test 3: back-pressure holds the presented beat
    bus_a.in_vec    = 32'h0000_0F00;
    bus_a.in_valid  = 1'b1;
    bus_a.out_ready = 1'b0;
    tick();
    bus_a.in_valid = 1'b0;
    for (int c = 0; c < 3; c++) begin
      check($sformatf("t3_hold_valid%0d", c),   bus_a.out_valid, 1);
      check($sformatf("t3_hold_idx%0d", c),     bus_a.out_idx,   8);
      check($sformatf("t3_hold_pending%0d", c), bus_a.pending,   4);
      check($sformatf("t3_hold_last%0d", c),    bus_a.out_last,  0);
      tick();
    end
    bus_a.out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      check($sformatf("t3_idx%0d", k),     bus_a.out_idx,  8 + k);
      check($sformatf("t3_pending%0d", k), bus_a.pending,  4 - k);
      check($sformatf("t3_last%0d", k),    bus_a.out_last, (k == 3) ? 1 : 0);
      tick();
    end
    check("t3_done_ready", bus_a.in_ready, 1);

    // Test 4: all-zero vector
    bus_a.in_vec   = 32'd0;
    bus_a.in_valid = 1'b1;
    tick();
    bus_a.in_valid = 1'b0;
    check("t4_err_pulse", bus_a.empty_err, 1);
    check("t4_valid",     bus_a.out_valid, 0);
    check("t4_in_ready",  bus_a.in_ready,  1);
    tick();
    check("t4_err_clear", bus_a.empty_err, 0);
    check("t4_valid2",    bus_a.out_valid, 0);

    // Test 5: all 32 bits, with in_valid pulses during SCAN that must be ignored
    bus_a.in_vec   = 32'hFFFF_FFFF;
    bus_a.in_valid = 1'b1;
    tick();
    bus_a.in_valid = 1'b0;
    for (int i = 0; i < 32; i++) begin
      check($sformatf("t5_idx%0d", i),     bus_a.out_idx,  i);
      check($sformatf("t5_pending%0d", i), bus_a.pending,  32 - i);
      check($sformatf("t5_last%0d", i),    bus_a.out_last, (i == 31) ? 1 : 0);
      bus_a.in_valid = i[0];
      bus_a.in_vec   = 32'h0000_0001;
      tick();
    end
    bus_a.in_valid = 1'b0;
    check("t5_done_ready", bus_a.in_ready,  1);
    check("t5_done_valid", bus_a.out_valid, 0);
    check("t5_done_pend",  bus_a.pending,   0);

    // Test 6: reset during beat 2 of a full vector
    bus_a.in_vec   = 32'hFFFF_FFFF;
    bus_a.in_valid = 1'b1;
    tick();
    bus_a.in_valid = 1'b0;
    check("t6_beat0", bus_a.out_idx, 0);
    tick();
    check("t6_beat1", bus_a.out_idx, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("t6_rst_valid",   bus_a.out_valid, 0);
    check("t6_rst_pending", bus_a.pending,   0);
    check("t6_rst_ready",   bus_a.in_ready,  1);
    check("t6_rst_last",    bus_a.out_last,  0);

    // Round trip of every one-hot code produced by a 5-to-32 decoder
    for (int code = 0; code < 32; code++) begin
      bus_a.in_vec   = 32'd1 << code;
      bus_a.in_valid = 1'b1;
      tick();
      bus_a.in_valid = 1'b0;
      check($sformatf("rt_idx%0d", code),  bus_a.out_idx,  code);
      check($sformatf("rt_last%0d", code), bus_a.out_last, 1);
      check($sformatf("rt_pend%0d", code), bus_a.pending,  1);
      tick();
      check($sformatf("rt_idle%0d", code), bus_a.out_valid, 0);
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
